disp_4cd_scan: RTL and testbench
================================

DISP_4CD_SCAN -- requirements
Module: disp_4cd_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot (>=2).
REQ-002 SHALL have parameter BLANK_LZ, default 1: 1 enables leading-zero blanking.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port DEC  input  16  four BCD digits; [15:12] leftmost (slot 3) ... [3:0] rightmost (slot 0).
REQ-006 SHALL have port en  input  1  scan enable.
REQ-007 SHALL have port dp_mask  input  4  bit i=1 lights the decimal point in slot i.
REQ-008 SHALL have port blink  input  4  bit i=1 blinks digit i.
REQ-009 SHALL have port AN  output  4  active-low digit anodes, bit i = slot i.
REQ-010 SHALL have port SEG  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port DP  output  1  active-low decimal point.
REQ-012 SHALL have port frame  output  1  one-cycle pulse at each new frame.

Function
REQ-013 SHALL run a prescaler counting 0..SCAN_DIV-1 while en=1 and holding while en=0; tick = en & (count==SCAN_DIV-1); count wraps to 0 on tick.
REQ-014 SHALL advance a 2-bit slot index 0->1->2->3->0 on each tick; index holds otherwise.
REQ-015 SHALL latch DEC into a 16-bit snapshot on the tick that moves index 3->0, and on the first cycle after rst_n returns high; all displayed digits come from the snapshot only.
REQ-016 SHALL assert frame for exactly one cycle, the cycle after each snapshot load.
REQ-017 SHALL keep a 6-bit frame counter incremented per frame pulse; blink phase = counter MSB.
REQ-018 SHALL register AN, SEG, DP: values at cycle n+1 are a function of index, snapshot, en, dp_mask, blink, phase at cycle n.
REQ-019 SHALL drive AN with a single 0 at bit index when en=1; AN=4'b1111 when en=0.
REQ-020 SHALL decode nibble 0..9 to SEG: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-021 SHALL display nibbles 0xA..0xF as dash (SEG=0111111).
REQ-022 SHALL, with BLANK_LZ=1, blank slot k (k=3,2,1) when its digit and all higher digits are 0; slot 0 is never LZ-blanked.
REQ-023 SHALL blank slot i when blink[i]=1 and phase=1.
REQ-024 SHALL, for a blanked slot, drive SEG=1111111 and DP=1 with AN still selecting the slot.
REQ-025 SHALL drive DP=~dp_mask[index] for non-blanked slots when en=1, else DP=1.
REQ-026 SHALL resume, after en falls and rises again, from the held index and prescaler count with no snapshot reload.

Reset
REQ-027 SHALL, while rst_n=0 at a clk edge, set prescaler=0, index=0, snapshot=0, frame counter=0, AN=1111, SEG=1111111, DP=1, frame=0; rst_n=0 mid-frame overrides all other activity.

Verification
REQ-028 SCAN_DIV=4, DEC=16'h1234, en=1 after reset -> AN 1110/SEG 0011001, 1101/0110000, 1011/0100100, 0111/1111001, each held 4 cycles, repeating.
REQ-029 DEC=16'h0005, BLANK_LZ=1 -> slot 0 SEG 0010010; slots 1-3 SEG 1111111; DEC=16'h0000 -> slot 0 shows 1000000; DEC=16'h0105 -> slot 2 shows 1, slot 1 shows 0.
REQ-030 DEC changes 1234->5678 while index=1 -> slots 1-3 still show 3,2,1; 5678 appears after the next 3->0 tick, with frame pulsing for one cycle.
REQ-031 en low at index=2 -> next cycle AN=1111, DP=1; index and count frozen; en high -> slot 2 completes its remaining cycles.
REQ-032 DEC=16'h00A0, dp_mask=0001 -> slot 1 dash 0111111, DP=0 only during slot 0; blink=0001 -> slot 0 blank during frames 32-63 of each 64.
REQ-033 rst_n low during slot 2 -> next edge outputs AN=1111, SEG=1111111, DP=1, frame=0; scan restarts at slot 0 after release.

Source files
------------

// File: rtl/disp_4cd_scan.sv
// Four-digit multiplexed 7-segment scanner with a per-frame digit snapshot,
// leading-zero blanking, per-digit blink and decimal points. All outputs are registered.
module disp_4cd_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] DEC,
  input  logic        en,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame
);

  localparam int unsigned CNT_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FCNT_W = 6;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       snap_q, snap_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              first_q;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d, frame_q, frame_d;

  logic       tick_c, load_c, blank_c;
  logic [3:0] nib_c;
  logic       z3_c, z2_c, z1_c, lz_c;

  // Scan timing, snapshot capture and output decode.
  always_comb begin
    tick_c  = en && (cnt_q == CNT_W'(SCAN_DIV - 1));
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (tick_c) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Capture on the slot 3 -> 0 wrap, and once right after reset release.
    load_c  = first_q || (tick_c && (idx_q == 2'd3));
    snap_d  = load_c ? DEC : snap_q;
    frame_d = load_c;
    fcnt_d  = fcnt_q + FCNT_W'(load_c);

    case (idx_q)
      2'd0:    nib_c = snap_q[3:0];
      2'd1:    nib_c = snap_q[7:4];
      2'd2:    nib_c = snap_q[11:8];
      default: nib_c = snap_q[15:12];
    endcase

    z3_c = (snap_q[15:12] == 4'd0);
    z2_c = z3_c && (snap_q[11:8] == 4'd0);
    z1_c = z2_c && (snap_q[7:4] == 4'd0);
    case (idx_q)
      2'd3:    lz_c = z3_c;
      2'd2:    lz_c = z2_c;
      2'd1:    lz_c = z1_c;
      default: lz_c = 1'b0;
    endcase
    blank_c = (BLANK_LZ && lz_c) || (blink[idx_q] && fcnt_q[FCNT_W-1]);

    an_d = en ? ~(4'b0001 << idx_q) : 4'b1111;
    case (nib_c)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b0111111;
    endcase
    dp_d = ~dp_mask[idx_q];
    if (!en || blank_c) begin
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      fcnt_q  <= '0;
      first_q <= 1'b1;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      fcnt_q  <= fcnt_d;
      first_q <= 1'b0;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign AN    = an_q;
  assign SEG   = seg_q;
  assign DP    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_disp_4cd_scan.sv
// Directed scoreboard bench for disp_4cd_scan with SCAN_DIV=4: expected display
// states are queued before each clock edge and compared one edge later.
module tb_disp_4cd_scan;

  localparam int unsigned DIV = 4;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frm;
    logic       chk_seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dec;
  logic        en;
  logic [3:0]  dp_mask;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          frames = 0;
  logic [15:0] cur_snap = 16'h0;
  logic [15:0] pending = 16'h0;

  disp_4cd_scan #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .DEC(dec), .en(en), .dp_mask(dp_mask),
    .blink(blink), .AN(an), .SEG(seg), .DP(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic exp_t slot_exp(input int k, input logic [15:0] s, input logic [3:0] dpm,
                                    input logic [3:0] blk, input logic ph, input logic frm);
    exp_t        e;
    logic [15:0] t;
    logic        bl;
    t  = s >> (4 * k);
    bl = (k == 3 && s[15:12] == 4'h0) || (k == 2 && s[15:8] == 8'h0) ||
         (k == 1 && s[15:4] == 12'h0) || (blk[k] && ph);
    e.an      = ~(4'b0001 << k);
    e.seg     = bl ? 7'b1111111 : seg_of(t[3:0]);
    e.dp      = bl ? 1'b1 : ~dpm[k];
    e.frm     = frm;
    e.chk_seg = 1'b1;
    return e;
  endfunction

  function automatic logic phase_of(input int f);
    return ((f / 32) % 2) == 1;
  endfunction

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (q.size() != 0) else begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      assert (an === e.an) else begin
        errors++; $error("FAIL %s AN: got %b expected %b", tag, an, e.an);
      end
      checks++;
      assert (dp === e.dp) else begin
        errors++; $error("FAIL %s DP: got %b expected %b", tag, dp, e.dp);
      end
      checks++;
      assert (frame === e.frm) else begin
        errors++; $error("FAIL %s frame: got %b expected %b", tag, frame, e.frm);
      end
      if (e.chk_seg) begin
        checks++;
        assert (seg === e.seg) else begin
          errors++; $error("FAIL %s SEG: got %b expected %b", tag, seg, e.seg);
        end
      end
    end
  endtask

  task automatic run_slot(input int k, input int n);
    logic last;
    for (int i = 0; i < n; i++) begin
      last = (k == 3) && (i == n - 1);
      if (last) pending = dec;
      q.push_back(slot_exp(k, cur_snap, dp_mask, blink, phase_of(frames), last));
      tick_check($sformatf("slot%0d", k));
    end
    if (k == 3 && n == int'(DIV)) begin
      cur_snap = pending;
      frames++;
    end
  endtask

  task automatic run_frame();
    for (int k = 0; k < 4; k++) run_slot(k, DIV);
  endtask

  task automatic apply_reset();
    exp_t e;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, frm: 1'b0, chk_seg: 1'b1};
      q.push_back(e);
      tick_check("reset");
    end
    frames   = 0;
    cur_snap = 16'h0;
  endtask

  // First cycle after release still shows the cleared snapshot and pulses frame.
  task automatic start_run();
    rst_n = 1'b1;
    pending = dec;
    q.push_back(slot_exp(0, 16'h0, dp_mask, blink, 1'b0, 1'b1));
    tick_check("first");
    cur_snap = pending;
    frames   = 1;
    run_slot(0, DIV - 1);
    for (int k = 1; k < 4; k++) run_slot(k, DIV);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; en = 1'b1; dec = 16'h1234; dp_mask = 4'h0; blink = 4'h0;
    apply_reset();
    start_run();
    run_frame();

    // DEC change while scanning slot 1 must not reach the display until the next frame.
    run_slot(0, DIV);
    run_slot(1, 2);
    dec = 16'h5678;
    run_slot(1, 2);
    run_slot(2, DIV);
    run_slot(3, DIV);
    run_frame();

    dec = 16'h0005; run_frame(); run_frame();
    dec = 16'h0000; run_frame(); run_frame();
    dec = 16'h0105; run_frame(); run_frame();
    dec = 16'h00A0; dp_mask = 4'b0001; run_frame(); run_frame();

    // Pause mid slot 2, then resume where the prescaler left off.
    run_slot(0, DIV);
    run_slot(1, DIV);
    run_slot(2, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, frm: 1'b0, chk_seg: 1'b0};
      q.push_back(e);
      tick_check("disabled");
    end
    en = 1'b1;
    run_slot(2, DIV - 1);
    run_slot(3, DIV);

    blink = 4'b0001;
    while (frames < 68) run_frame();
    blink = 4'b0000;

    dec = 16'h4321;
    run_frame();
    run_slot(0, DIV);
    run_slot(1, DIV);
    run_slot(2, 2);
    apply_reset();
    start_run();
    run_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
